sram_1rw1r_param: RTL
=====================

# sram_1rw1r_param

Parametrised, synthesizable single-clock 1RW+1R SRAM for the pedal's audio delay/effect buffers, with byte write masks, a configurable read pipeline, per-port read-valid strobes and a post-reset zero-fill sequencer. The zero-fill ensures delay lines start silent. It sits between the effect datapath (port 0: sample write and tap read) and the output mixer (port 1: delayed-tap read).

## Interface
- DATA_WIDTH, 16: word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 14: address width; depth = 2^ADDR_WIDTH words.
- BYTE_WIDTH, 8: bits per write-mask lane.
- NUM_WMASKS, DATA_WIDTH/BYTE_WIDTH: number of mask lanes (derived).
- READ_LATENCY, 1: cycles from read sample to dout; legal values 1 or 2.
- wb_clk_i  in  1  sole clock, rising-edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- csb0  in  1  port 0 select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  NUM_WMASKS  per-lane write enable, lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data; reset 0.
- dout0_valid  out  1  one-cycle strobe, dout0 updated this cycle; reset 0.
- csb1  in  1  port 1 select, active low.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data; reset 0.
- dout1_valid  out  1  one-cycle strobe; reset 0.
- init_busy  out  1  high while zero-fill runs; reset 1.

## Operation
- States: CLEAR, READY. Reset forces CLEAR with the fill pointer at 0. Reset asserted mid-fill restarts the fill at address 0.
- CLEAR: one word of zeros written per cycle at the fill pointer. All port requests are ignored: no write, no read, no valid strobes.
- CLEAR -> READY on the cycle after address 2^ADDR_WIDTH-1 is written. init_busy deasserts on the first READY cycle. Total fill time is 2^ADDR_WIDTH cycles after reset release.
- READY, port 0 write (csb0=0, web0=0): lanes with wmask0[i]=1 are updated at the sampling edge. An all-zero mask is a no-op. No read occurs, dout0 holds, and dout0_valid stays 0.
- READY, port 0 read (csb0=0, web0=1): mem[addr0] is returned on dout0 with dout0_valid.
- READY, port 1 read (csb1=0): mem[addr1] is returned on dout1 with dout1_valid.
- Deselected ports: dout holds its last value, never X. Valid is 0.
- Collision (port 0 write and port 1 read, same address, same cycle): the result is governed by SRAM_BYPASS_EN (see Configuration).

## Timing
- All inputs are sampled on the rising edge of wb_clk_i.
- READ_LATENCY=1: request sampled at edge N gives dout and valid at edge N+1.
- READ_LATENCY=2: an extra output register gives results at edge N+2. Valid is pipelined alongside the data.
- Full throughput: one operation per port per cycle, back-to-back, with no bubbles.
- A write at edge N is visible to any read sampled at edge N+1 or later.
- Reset clears the output pipeline registers and valids the same edge. An in-flight read is discarded.

## Configuration
- Macro SRAM_BYPASS_EN.
  - Defined: a collision returns the new merged word on dout1 (old bytes on unmasked lanes, din0 bytes on masked lanes); write-first behaviour.
  - Undefined: a collision returns the pre-write word (read-first).
- Port 0 has no collision case because it never reads and writes in the same cycle.

## Structure
- Package sram_pkg holds:
  - the state typedef (CLEAR, READY);
  - the default parameter constants;
  - the READ_LATENCY legal-value check constant.
- One sub-module, sram_out_pipe, is instantiated once per read port. It is parametrised by DATA_WIDTH and READ_LATENCY and carries the data and valid registers.
- The memory array, fill FSM and collision merge live in the top module.

## Test plan
Benches use DATA_WIDTH=16, ADDR_WIDTH=4, READ_LATENCY=1 unless noted.
- Zero-fill: release reset and hold csb0=0/web0=0 during fill. Required:
  - init_busy=1 for exactly 16 cycles;
  - reading addresses 0..15 afterwards returns 0x0000;
  - no writes during fill took effect.
- Byte mask: write 0xABCD to addr 3 with mask 2'b11, then write 0x1234 with mask 2'b01, then read addr 3 on port 0. Required: dout0=0xAB34 one cycle after the read, with dout0_valid pulsed once.
- Collision: addr 5 holds 0x1111; in the same cycle write 0x2222 (mask 2'b10) to addr 5 and read addr 5 on port 1. Required dout1:
  - with SRAM_BYPASS_EN: 0x2211;
  - without it: 0x1111;
  - in both cases, a later read returns 0x2211.
- Latency 2: READ_LATENCY=2, back-to-back port 1 reads of addr 1, 2, 3 holding 0x0001, 0x0002, 0x0003. Required:
  - dout1 shows 0x0001, 0x0002, 0x0003 on consecutive cycles starting 2 cycles after the first request;
  - dout1_valid is high for exactly 3 cycles.
- Reset mid-operation:
  - Assert reset at fill cycle 7. Required: init_busy stays high and the fill completes 16 cycles after release.
  - Assert reset during an in-flight read. Required: dout=0 and valid=0 on the next edge.
- Hold: read addr 2 (0x00AA), then deselect for 5 cycles. Required: dout0 stays 0x00AA and dout0_valid stays 0 throughout.

Source files
------------

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types and constants for the 1RW+1R delay-line SRAM.
//               Holds the fill-sequencer state type, the default parameter
//               values and the read-latency legality check.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // Zero-fill sequencer state: CLEAR while the array is being wiped,
  // READY once user traffic is accepted.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_t;

  localparam int c_DEF_DATA_WIDTH   = 16;
  localparam int c_DEF_ADDR_WIDTH   = 14;
  localparam int c_DEF_BYTE_WIDTH   = 8;
  localparam int c_DEF_READ_LATENCY = 1;

  // Only one or two output register stages are supported.
  localparam int c_RL_MIN = 1;
  localparam int c_RL_MAX = 2;

  function automatic bit read_latency_legal(input int rl);
    return (rl >= c_RL_MIN) && (rl <= c_RL_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_out_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_out_pipe
// Description : Read-data / read-valid output pipeline for one SRAM read port.
//               Stage 1 captures the array word on a read; with
//               READ_LATENCY=2 a second stage delays data and valid by one
//               more cycle. Data registers hold their last value when no read
//               completes, so a deselected port keeps showing old data.
// Ports       : clk          - clock
//               rst          - synchronous active-high reset (clears all)
//               i_rd_en      - a read is being sampled this edge
//               i_rd_data    - word read from the array this edge
//               o_dout       - registered read data
//               o_dout_valid - one-cycle strobe, o_dout updated
// Revision    : 1.0 - initial release
// ============================================================================
module sram_out_pipe
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = c_DEF_DATA_WIDTH,
  parameter int READ_LATENCY = c_DEF_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dout_valid
);

  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= i_rd_en;
      if (i_rd_en) begin
        r_s1_data <= i_rd_data;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_s2_data;
      logic                  r_s2_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_data  <= '0;
          r_s2_valid <= 1'b0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign o_dout       = r_s2_data;
      assign o_dout_valid = r_s2_valid;
    end else begin : g_lat1
      assign o_dout       = r_s1_data;
      assign o_dout_valid = r_s1_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw1r_param
// Description : Single-clock 1RW+1R SRAM for audio delay/effect buffers.
//               Byte-masked writes on port 0, reads on both ports with a
//               1- or 2-cycle output pipeline and per-port valid strobes.
//               After reset the whole array is zero-filled (one word per
//               cycle) so delay lines start silent; user requests are
//               ignored while init_busy is high.
// Config      : `define SRAM_BYPASS_EN -> a port-1 read colliding with a
//               port-0 write to the same address returns the newly merged
//               word (write-first). Undefined -> returns the old word
//               (read-first).
// Ports       : wb_clk_i    - clock, rising edge
//               wb_rst_i    - synchronous active-high reset
//               csb0/web0   - port 0 select / write enable (active low)
//               wmask0      - port 0 per-byte write lanes
//               addr0/din0  - port 0 address / write data
//               dout0/dout0_valid - port 0 read data / strobe
//               csb1/addr1  - port 1 select (active low) / address
//               dout1/dout1_valid - port 1 read data / strobe
//               init_busy   - high while the zero-fill runs
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = c_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = c_DEF_ADDR_WIDTH,
  parameter int BYTE_WIDTH   = c_DEF_BYTE_WIDTH,
  parameter int NUM_WMASKS   = DATA_WIDTH / BYTE_WIDTH,
  parameter int READ_LATENCY = c_DEF_READ_LATENCY
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_busy
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  generate
    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
      $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  sram_state_t           r_state;
  sram_state_t           w_state_next;
  logic [ADDR_WIDTH-1:0] r_fill_ptr;
  logic                  w_fill_we;
  logic                  w_ready;
  logic                  w_fill_last;

  // ---------------------------------------------------------------- fill FSM
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (w_fill_last) w_state_next = READY;
      READY:   w_state_next = READY;
      default: w_state_next = CLEAR;
    endcase
  end

  always_comb begin
    w_fill_we = 1'b0;
    w_ready   = 1'b0;
    case (r_state)
      CLEAR:   w_fill_we = 1'b1;
      READY:   w_ready   = 1'b1;
      default: w_fill_we = 1'b1;
    endcase
  end

  assign init_busy   = ~w_ready;
  assign w_fill_last = w_fill_we & (&r_fill_ptr);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_fill_ptr <= '0;
    end else if (w_fill_we) begin
      r_fill_ptr <= r_fill_ptr + 1'b1;
    end
  end

  // ------------------------------------------------------- request decoding
  logic w_wr_en;
  logic w_rd0_en;
  logic w_rd1_en;

  assign w_wr_en  = w_ready & ~csb0 & ~web0;
  assign w_rd0_en = w_ready & ~csb0 &  web0;
  assign w_rd1_en = w_ready & ~csb1;

  // --------------------------------------------------- write-lane merge
  // The merged word is what port 0's address holds after this edge; it is
  // written back whole (an all-zero mask rewrites the old word unchanged)
  // and, when bypass is enabled, forwarded to a colliding port-1 read.
  logic [DATA_WIDTH-1:0] w_old0;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_old0 = r_mem[addr0];

  generate
    for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
      assign w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
        wmask0[i] ? din0[i*BYTE_WIDTH +: BYTE_WIDTH]
                  : w_old0[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (w_fill_we) begin
        r_mem[r_fill_ptr] <= '0;
      end else if (w_wr_en) begin
        r_mem[addr0] <= w_merged;
      end
    end
  end

  // ---------------------------------------------------------- read paths
  logic [DATA_WIDTH-1:0] w_rd1_raw;
  logic [DATA_WIDTH-1:0] w_rd1_data;

  assign w_rd1_raw = r_mem[addr1];

`ifdef SRAM_BYPASS_EN
  logic w_collide;
  assign w_collide  = w_wr_en & w_rd1_en & (addr0 == addr1);
  assign w_rd1_data = w_collide ? w_merged : w_rd1_raw;
`else
  // Array reads see the pre-edge contents, so a collision is read-first.
  assign w_rd1_data = w_rd1_raw;
`endif

  sram_out_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe0 (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .i_rd_en      (w_rd0_en),
    .i_rd_data    (w_old0),
    .o_dout       (dout0),
    .o_dout_valid (dout0_valid)
  );

  sram_out_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe1 (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .i_rd_en      (w_rd1_en),
    .i_rd_data    (w_rd1_data),
    .o_dout       (dout1),
    .o_dout_valid (dout1_valid)
  );

endmodule
`default_nettype wire
